sw_debounce: RTL

- Input conditioning stage placed directly upstream of the half adder.
- Takes raw, asynchronous, bouncing slide-switch levels and synchronises each bit into the system clock domain.
- Debounces each bit independently and presents clean levels that drive the adder operands (A_in = sw_db[0], B_in = sw_db[1]).
- Also emits single-cycle rise/fall strobes so downstream logic can react to operand changes.

---
 rtl/sw_debounce.sv | 88 ++++++++
 1 files changed

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module  : sw_debounce
// Brief   : Two-flop synchroniser plus per-bit debounce with registered
//           rise/fall/change strobes, feeding the half-adder operand bus.
// Rev     : 1.0
// ============================================================================
module sw_debounce #(
    parameter int N_SW            = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] sws_tri_i,
    output logic [N_SW-1:0] sw_db,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic            sw_change
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_SW-1:0] sync1;
    logic [N_SW-1:0] sync2;
    logic [N_SW-1:0] db_next;
    logic [N_SW-1:0] rise_next;
    logic [N_SW-1:0] fall_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sws_tri_i;
            sync2 <= sync1;
        end
    end

    // Channel state is {sw_db[i], cnt}: cnt == 0 means stable, cnt > 0 pending.
    generate
        for (genvar i = 0; i < N_SW; i++) begin : g_chan
            logic [CNT_W-1:0] cnt;
            logic [CNT_W-1:0] cnt_next;
            logic             accept;

            always_comb begin
                cnt_next = '0;
                accept   = 1'b0;
                if (sync2[i] != sw_db[i]) begin
                    if (cnt == CNT_LAST) begin
                        accept = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt_next;
                end
            end

            assign db_next[i]   = accept ? sync2[i] : sw_db[i];
            assign rise_next[i] = accept &  sync2[i];
            assign fall_next[i] = accept & ~sync2[i];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_db     <= '0;
            sw_rise   <= '0;
            sw_fall   <= '0;
            sw_change <= 1'b0;
        end else begin
            sw_db     <= db_next;
            sw_rise   <= rise_next;
            sw_fall   <= fall_next;
            sw_change <= |{rise_next, fall_next};
        end
    end

endmodule
`default_nettype wire
